// File: rtl/ufp_mul_sched.sv
// Round-robin share of one LAT-stage UQ IW.QW multiplier; result lands in the requester's buffer LAT cycles after grant.
// Per-requester busy credit means the pipe never stalls; defining UFP_MUL_SCHED_SAT_EN saturates overflowed results.
module ufp_mul_sched #(
  parameter int NREQ = 4,
  parameter int IW   = 8,
  parameter int QW   = 8,
  parameter int LAT  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*(IW+QW)-1:0] req_a_i,
  input  logic [NREQ*(IW+QW)-1:0] req_b_i,
  output logic [NREQ-1:0]        rsp_valid_o,
  input  logic [NREQ-1:0]        rsp_ready_i,
  output logic [NREQ*(IW+QW)-1:0] rsp_val_o,
  output logic [NREQ-1:0]        rsp_ovf_o
);
  localparam int WL  = IW + QW;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] busy, pop, pop_q, elig, grant;
  logic [IDW-1:0]  ptr, gid, idx;
  logic            found;

  assign pop  = rsp_valid_o & rsp_ready_i;
  // Reset also masks eligibility so req_ready_o is forced low while rst_ni is asserted.
  assign elig = req_valid_i & ~busy & {NREQ{rst_ni}};

  always_comb begin
    found = 1'b0;
    gid   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[gid] = 1'b1;
  end

  assign req_ready_o = grant;

  logic [WL-1:0]   op_a, op_b, s0_val;
  logic [2*WL-1:0] prod;
  logic            s0_ovf;

  assign op_a   = req_a_i[gid*WL +: WL];
  assign op_b   = req_b_i[gid*WL +: WL];
  // Product is formed at issue and carried down the stages; retiming spreads it.
  assign prod   = (2*WL)'(op_a) * (2*WL)'(op_b);
  assign s0_ovf = |prod[2*WL-1:WL+QW];
`ifdef UFP_MUL_SCHED_SAT_EN
  assign s0_val = s0_ovf ? {WL{1'b1}} : prod[WL+QW-1:QW];
`else
  assign s0_val = prod[WL+QW-1:QW];
`endif

  logic           tail_vld, tail_ovf;
  logic [IDW-1:0] tail_id;
  logic [WL-1:0]  tail_val;

  generate
    if (LAT == 1) begin : g_direct
      assign tail_vld = found;
      assign tail_id  = gid;
      assign tail_val = s0_val;
      assign tail_ovf = s0_ovf;
    end else begin : g_pipe
      logic [LAT-1:1] p_vld, p_ovf;
      logic [IDW-1:0] p_id  [LAT-1:1];
      logic [WL-1:0]  p_val [LAT-1:1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          p_vld <= '0;
          p_ovf <= '0;
          for (int k = 1; k < LAT; k++) begin
            p_id[k]  <= '0;
            p_val[k] <= '0;
          end
        end else begin
          p_vld[1] <= found;
          p_id[1]  <= gid;
          p_val[1] <= s0_val;
          p_ovf[1] <= s0_ovf;
          for (int k = 2; k < LAT; k++) begin
            p_vld[k] <= p_vld[k-1];
            p_id[k]  <= p_id[k-1];
            p_val[k] <= p_val[k-1];
            p_ovf[k] <= p_ovf[k-1];
          end
        end
      end

      assign tail_vld = p_vld[LAT-1];
      assign tail_id  = p_id[LAT-1];
      assign tail_val = p_val[LAT-1];
      assign tail_ovf = p_ovf[LAT-1];
    end
  endgenerate

  // busy is released one cycle after the pop is registered, so a popping requester skips a cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy  <= '0;
      pop_q <= '0;
      ptr   <= '0;
    end else begin
      pop_q <= pop;
      busy  <= (busy & ~pop_q) | grant;
      if (found) ptr <= (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= '0;
      rsp_val_o   <= '0;
      rsp_ovf_o   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (tail_vld && tail_id == IDW'(i)) begin
          rsp_valid_o[i]         <= 1'b1;
          rsp_val_o[i*WL +: WL]  <= tail_val;
          rsp_ovf_o[i]           <= tail_ovf;
        end else if (pop[i]) begin
          rsp_valid_o[i]         <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ufp_mul_sched.sv
// Scoreboarded random bench for ufp_mul_sched with a cycle-count reference model of grants and responses.
module tb_ufp_mul_sched;
  localparam int NREQ = 4, IW = 8, QW = 8, LAT = 3;
  localparam int WL = IW + QW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, rsp_ovf;
  logic [NREQ*WL-1:0] req_a = '0, req_b = '0, rsp_val;

  ufp_mul_sched #(.NREQ(NREQ), .IW(IW), .QW(QW), .LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_val_o(rsp_val), .rsp_ovf_o(rsp_ovf)
  );

  typedef struct packed { logic [WL-1:0] val; logic ovf; } exp_t;

  int n_tests = 0, n_fail = 0;
  exp_t expq[NREQ][$];

  bit            pend[NREQ], inflight[NREQ];
  int            rdy_cyc[NREQ], free_cyc[NREQ];
  logic [WL-1:0] op_a[NREQ], op_b[NREQ];
  int            ptr = 0, cyc = 0;

  function automatic exp_t ref_mul(input logic [WL-1:0] a, input logic [WL-1:0] b);
    logic [63:0] s;
    exp_t r;
    s = (64'(a) * 64'(b)) >> QW;
    r.ovf = (s >= (64'd1 << WL));
`ifdef UFP_MUL_SCHED_SAT_EN
    r.val = r.ovf ? {WL{1'b1}} : s[WL-1:0];
`else
    r.val = s[WL-1:0];
`endif
    return r;
  endfunction

  function automatic logic [WL-1:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    return r[WL-1:0] >> $urandom_range(0, 12);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: result visible LAT cycles after grant; requester eligible again 2 cycles after its pop.
  task automatic model_check();
    logic [NREQ-1:0] ev, eg;
    int g, id;
    for (int i = 0; i < NREQ; i++) ev[i] = inflight[i] && (cyc >= rdy_cyc[i]);
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      id = (ptr + k) % NREQ;
      if (g < 0 && pend[id] && !inflight[id] && cyc >= free_cyc[id]) g = id;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("grant", 64'(req_ready), 64'(eg));
    for (int i = 0; i < NREQ; i++)
      if (ev[i] && rsp_ready[i]) begin
        inflight[i] = 0;
        free_cyc[i] = cyc + 2;
      end
    if (g >= 0) begin
      pend[g]     = 0;
      inflight[g] = 1;
      rdy_cyc[g]  = cyc + LAT;
      expq[g].push_back(ref_mul(op_a[g], op_b[g]));
      ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic step(input int vprob, input logic [NREQ-1:0] rdy);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < vprob) begin
        pend[i] = 1;
        op_a[i] = rnd_op();
        op_b[i] = rnd_op();
      end
      req_valid[i]         = pend[i];
      req_a[i*WL +: WL]    = op_a[i];
      req_b[i*WL +: WL]    = op_b[i];
    end
    rsp_ready = rdy;
    @(negedge clk);
    model_check();
    cyc++;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_val", 64'(rsp_val), 64'd0);
    chk("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
    for (int i = 0; i < NREQ; i++) begin
      expq[i].delete();
      pend[i] = 0;
      inflight[i] = 0;
      free_cyc[i] = 0;
      rdy_cyc[i] = 0;
    end
    ptr = 0;
    cyc = 0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks held results stay put.
  initial begin
    logic [NREQ-1:0]    hold, hovf;
    logic [NREQ*WL-1:0] hval;
    exp_t e;
    hold = '0;
    hovf = '0;
    hval = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = '0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (hold[i]) begin
            n_tests++;
            if (!rsp_valid[i] || rsp_val[i*WL +: WL] !== hval[i*WL +: WL] || rsp_ovf[i] !== hovf[i]) begin
              n_fail++;
              $display("FAIL hold%0d: got vld %b val %h ovf %b expected vld 1 val %h ovf %b",
                       i, rsp_valid[i], rsp_val[i*WL +: WL], rsp_ovf[i], hval[i*WL +: WL], hovf[i]);
            end
          end
          if (rsp_valid[i] && rsp_ready[i]) begin
            n_tests++;
            if (expq[i].size() == 0) begin
              n_fail++;
              $display("FAIL rsp%0d: got val %h with no expected result pending", i, rsp_val[i*WL +: WL]);
            end else begin
              e = expq[i].pop_front();
              if (rsp_val[i*WL +: WL] !== e.val || rsp_ovf[i] !== e.ovf) begin
                n_fail++;
                $display("FAIL rsp%0d: got val %h ovf %b expected val %h ovf %b",
                         i, rsp_val[i*WL +: WL], rsp_ovf[i], e.val, e.ovf);
              end
            end
          end
        end
        hold = rsp_valid & ~rsp_ready;
        hval = rsp_val;
        hovf = rsp_ovf;
      end
    end
  end

  initial begin
    logic [15:0] ta[NREQ], tb_[NREQ];
    int left;
    ta  = '{16'h0180, 16'h8000, 16'h0001, 16'h1234};
    tb_ = '{16'h0200, 16'h0200, 16'h0001, 16'h0100};
    do_reset();

    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1;
      op_a[i] = ta[i];
      op_b[i] = tb_[i];
    end
    repeat (8) step(100, '1);

    repeat (14) step(100, {1'b0, 3'($urandom)});
    repeat (6) step(100, '1);

    repeat (300) step(40, NREQ'($urandom));

    repeat (5) step(100, '1);
    do_reset();
    repeat (200) step(60, NREQ'($urandom) | 4'b0101);

    repeat (20) step(0, '1);
    left = 0;
    for (int i = 0; i < NREQ; i++) left += expq[i].size();
    chk("drain_empty", 64'(left), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
